// File: rtl/gnpu_mac_pkg.sv
// Shared definitions for the multi-precision MAC processing element:
// precision codes, code width and per-precision lane geometry.
package gnpu_mac_pkg;

  localparam int unsigned PREC_W = 2;

  typedef enum logic [PREC_W-1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_INT32 = 2'd2,
    PREC_RSVD  = 2'd3
  } prec_e;

  localparam int unsigned LANE_W_INT8  = 8;
  localparam int unsigned LANE_W_INT16 = 16;
  localparam int unsigned LANE_W_INT32 = 32;

  // Number of packed lanes in a data_w-bit word at the given precision.
  function automatic int unsigned lane_count(input int unsigned data_w, input prec_e prec);
    case (prec)
      PREC_INT8:  return data_w / LANE_W_INT8;
      PREC_INT16: return data_w / LANE_W_INT16;
      PREC_INT32: return data_w / LANE_W_INT32;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/mac_mp_mul.sv
// Combinational packed multi-precision signed multiplier producing the lane
// products captured by the first pipeline stage of mac_mp.
module mac_mp_mul
  import gnpu_mac_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  prec_e               prec_i,
  output logic [2*DATA_W-1:0] prod_c
);

  localparam int unsigned L8  = lane_count(DATA_W, PREC_INT8);
  localparam int unsigned L16 = lane_count(DATA_W, PREC_INT16);
  localparam int unsigned L32 = lane_count(DATA_W, PREC_INT32);

  // Low half of the product of sign-extended operands is the exact signed product.
  function automatic logic [15:0] smul8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xe;
    logic [15:0] ye;
    xe = {{8{x[7]}}, x};
    ye = {{8{y[7]}}, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] smul16(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xe;
    logic [31:0] ye;
    xe = {{16{x[15]}}, x};
    ye = {{16{y[15]}}, y};
    return xe * ye;
  endfunction

  // int8 lanes are 16-bit slots; int16/int32 lanes are 32-bit slots from the LSB.
  always_comb begin
    prod_c = '0;
    case (prec_i)
      PREC_INT8: begin
        for (int i = 0; i < L8; i++) begin
          prod_c[16*i +: 16] = smul8(a_i[8*i +: 8], b_i[8*i +: 8]);
        end
      end
      PREC_INT16: begin
        for (int i = 0; i < L16; i++) begin
          prod_c[32*i +: 32] = smul16(a_i[16*i +: 16], b_i[16*i +: 16]);
        end
      end
      PREC_INT32: begin
        for (int i = 0; i < L32; i++) begin
          prod_c[32*i +: 32] = a_i[32*i +: 32] * b_i[32*i +: 32];
        end
      end
      default: prod_c = '0;
    endcase
  end

endmodule

// File: rtl/mac_mp.sv
// Two-stage multi-precision MAC processing element with preloadable accumulator.
// Define GNPU_MAC_SATURATE_EN to clamp the accumulate to the signed DATA_W range.
module mac_mp
  import gnpu_mac_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PREC_W = gnpu_mac_pkg::PREC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_valid_i,
  input  logic [DATA_W-1:0] c_data_i,
  input  logic              cal_valid_i,
  input  logic [PREC_W-1:0] cal_precision_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_valid_o,
  output logic              busy_o,
  output logic              prec_err_o
);

  localparam int unsigned L8  = lane_count(DATA_W, PREC_INT8);
  localparam int unsigned L16 = lane_count(DATA_W, PREC_INT16);
  localparam int unsigned L32 = lane_count(DATA_W, PREC_INT32);
`ifdef GNPU_MAC_SATURATE_EN
  localparam int unsigned SUM_W = DATA_W + $clog2(L8) + 1;
`else
  localparam int unsigned SUM_W = DATA_W;
`endif

  logic                s1_valid_q, s1_valid_d;
  prec_e               prec_q, prec_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                s2_valid_q, s2_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                prec_err_q, prec_err_d;
  logic [DATA_W-1:0]   acc_q, acc_d;

  logic [2*DATA_W-1:0] prod_c;
  logic                rsvd_c;
  logic [SUM_W-1:0]    lane_sum;
  logic [DATA_W-1:0]   acc_sum;
`ifdef GNPU_MAC_SATURATE_EN
  logic [SUM_W-1:0]    wide_sum;
`endif

  mac_mp_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .a_i    (a_data_i),
    .b_i    (b_data_i),
    .prec_i (prec_e'(cal_precision_i[1:0])),
    .prod_c (prod_c)
  );

  assign rsvd_c = (cal_precision_i >= PREC_W'(PREC_RSVD));

  // Reduce the registered lane products to one signed sum.
  always_comb begin
    lane_sum = '0;
    case (prec_q)
      PREC_INT8: begin
        for (int i = 0; i < L8; i++) begin
          lane_sum = lane_sum + SUM_W'($signed(prod_q[16*i +: 16]));
        end
      end
      PREC_INT16: begin
        for (int i = 0; i < L16; i++) begin
          lane_sum = lane_sum + SUM_W'($signed(prod_q[32*i +: 32]));
        end
      end
      PREC_INT32: begin
        for (int i = 0; i < L32; i++) begin
          lane_sum = lane_sum + SUM_W'($signed(prod_q[32*i +: 32]));
        end
      end
      default: lane_sum = '0;
    endcase
  end

  always_comb begin
`ifdef GNPU_MAC_SATURATE_EN
    wide_sum = SUM_W'($signed(acc_q)) + lane_sum;
    if ((wide_sum[SUM_W-1:DATA_W-1] == '0) || (wide_sum[SUM_W-1:DATA_W-1] == '1)) begin
      acc_sum = wide_sum[DATA_W-1:0];
    end else if (wide_sum[SUM_W-1]) begin
      acc_sum = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      acc_sum = {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    acc_sum = acc_q + lane_sum;
`endif
  end

  // Preload beats an S2 result in the same cycle; the S2 slot is still retired.
  always_comb begin
    s1_valid_d = cal_valid_i & ~rsvd_c;
    prec_err_d = cal_valid_i & rsvd_c;
    prod_d     = prod_q;
    prec_d     = prec_q;
    if (s1_valid_d) begin
      prod_d = prod_c;
      prec_d = prec_e'(cal_precision_i[1:0]);
    end
    s2_valid_d = s1_valid_q;
    d_valid_d  = s1_valid_q & ~c_valid_i;
    acc_d      = acc_q;
    if (c_valid_i) begin
      acc_d = c_data_i;
    end else if (s1_valid_q) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      prec_q     <= PREC_INT8;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      prec_err_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prec_q     <= prec_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      d_valid_q  <= d_valid_d;
      prec_err_q <= prec_err_d;
      acc_q      <= acc_d;
    end
  end

  assign d_data_o   = acc_q;
  assign d_valid_o  = d_valid_q;
  assign prec_err_o = prec_err_q;
  assign busy_o     = s1_valid_q | s2_valid_q;

endmodule
